// File: rtl/gate16_checker.sv
// Response checker for the 16-bit bitwise gate units: samples the gate output,
// recomputes the expected value, counts pass/fail and latches the first mismatch.
module gate16_checker #(
    parameter int WIDTH = 16,
    parameter int OP    = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_y
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;

    logic             s_valid;
    logic             s_last;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] y_r;
    logic [CNT_W-1:0] s_idx;
    logic [CNT_W-1:0] idx;

    logic [WIDTH-1:0] exp_y;
    logic             match;
    logic             bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Unknown OP codes fall back to AND.
    always_comb begin
        exp_y = a_r & b_r;
        case (OP)
            1:       exp_y = a_r | b_r;
            2:       exp_y = a_r ^ b_r;
            3:       exp_y = ~(a_r & b_r);
            default: exp_y = a_r & b_r;
        endcase
    end

    assign match  = (y_r == exp_y);
    // The last vector is in the compare stage: this edge ends the run, so
    // whatever arrives on the inputs now is not part of it.
    assign bubble = s_valid & s_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
            fail_a   <= '0;
            fail_b   <= '0;
            fail_y   <= '0;
            s_valid  <= 1'b0;
            s_last   <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            y_r      <= '0;
            s_idx    <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    s_valid <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        pass_cnt <= '0;
                        fail_cnt <= '0;
                        fail_idx <= '0;
                        fail_a   <= '0;
                        fail_b   <= '0;
                        fail_y   <= '0;
                        idx      <= '0;
                    end
                end

                RUN: begin
                    if (s_valid) begin
                        if (match) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                            if (!error) begin
                                error    <= 1'b1;
                                fail_idx <= s_idx;
                                fail_a   <= a_r;
                                fail_b   <= b_r;
                                fail_y   <= y_r;
                            end
                        end
                    end

                    if (valid && !bubble) begin
                        s_valid <= 1'b1;
                        s_last  <= last;
                        a_r     <= a;
                        b_r     <= b;
                        y_r     <= y;
                        s_idx   <= idx;
                        idx     <= sat_inc(idx);
                    end else begin
                        s_valid <= 1'b0;
                    end

                    if (bubble) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    s_valid <= 1'b0;
                end
            endcase
        end
    end

    a_busy_done_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(busy && done)
    );

    a_error_tracks_fail: assert property (
        @(posedge clk) disable iff (!rst_n) error == (fail_cnt != '0)
    );

endmodule

// File: tb/tb_gate16_checker.sv
// Bench for gate16_checker: directed scenario table plus randomized runs scored
// against a transaction-level model of the checker's counting rules.
module tb_gate16_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic        last;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y_drv [4];

    logic        busy_o [4];
    logic        done_o [4];
    logic        err_o  [4];
    logic [15:0] pass_o [4];
    logic [15:0] fail_o [4];
    logic [15:0] fidx_o [4];
    logic [15:0] fa_o   [4];
    logic [15:0] fb_o   [4];
    logic [15:0] fy_o   [4];

    logic        busy4;
    logic        done4;
    logic        err4;
    logic [1:0]  pass4;
    logic [1:0]  fail4;
    logic [1:0]  fidx4;
    logic [15:0] fa4;
    logic [15:0] fb4;
    logic [15:0] fy4;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            gate16_checker #(.WIDTH(16), .OP(g), .CNT_W(16)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .last(last),
                .a(a), .b(b), .y(y_drv[g]),
                .busy(busy_o[g]), .done(done_o[g]), .error(err_o[g]),
                .pass_cnt(pass_o[g]), .fail_cnt(fail_o[g]), .fail_idx(fidx_o[g]),
                .fail_a(fa_o[g]), .fail_b(fb_o[g]), .fail_y(fy_o[g])
            );
        end
    endgenerate

    // Narrow-counter instance for saturation; sees the same stream as the AND unit.
    gate16_checker #(.WIDTH(16), .OP(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .last(last),
        .a(a), .b(b), .y(y_drv[0]),
        .busy(busy4), .done(done4), .error(err4),
        .pass_cnt(pass4), .fail_cnt(fail4), .fail_idx(fidx4),
        .fail_a(fa4), .fail_b(fb4), .fail_y(fy4)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [4:0][15:0] y;
        logic [4:0][15:0] idx;
        logic             last;
    } vec_t;

    int          m_state;
    logic        m_err  [5];
    logic [15:0] m_pass [5];
    logic [15:0] m_fail [5];
    logic [15:0] m_fidx [5];
    logic [15:0] m_fa   [5];
    logic [15:0] m_fb   [5];
    logic [15:0] m_fy   [5];
    logic [15:0] m_idx  [5];
    vec_t        m_pipe [$];

    typedef struct {
        logic [3:0]  fault;
        logic [15:0] e_pass;
        logic [15:0] e_fail;
        logic        e_err;
        logic [15:0] e_idx;
        logic [15:0] e_fa;
        logic [15:0] e_fb;
        logic [15:0] e_fy;
    } scen_t;

    scen_t       scen [3];
    logic [15:0] va [4] = '{16'hffff, 16'hffff, 16'h0000, 16'h0000};
    logic [15:0] vb [4] = '{16'hffff, 16'h0000, 16'hffff, 16'h0000};

    function automatic int op_of(input int k);
        return (k == 4) ? 0 : k;
    endfunction

    function automatic logic [15:0] cmax(input int k);
        return (k == 4) ? 16'h0003 : 16'hffff;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v, input int k);
        return (v >= cmax(k)) ? cmax(k) : v + 16'd1;
    endfunction

    function automatic logic [15:0] ref_fn(input int op, input logic [15:0] x, input logic [15:0] z);
        case (op)
            1:       return x | z;
            2:       return x ^ z;
            3:       return ~(x & z);
            default: return x & z;
        endcase
    endfunction

    function automatic logic [15:0] rmask();
        return ($urandom_range(0, 3) == 0) ? 16'(16'h1 << $urandom_range(0, 15)) : 16'h0;
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int k = 0; k < 5; k++) begin
            m_err[k]  = 1'b0;
            m_pass[k] = '0;
            m_fail[k] = '0;
            m_fidx[k] = '0;
            m_fa[k]   = '0;
            m_fb[k]   = '0;
            m_fy[k]   = '0;
            m_idx[k]  = '0;
        end
        m_pipe.delete();
    endtask

    task automatic score(input vec_t v);
        logic [15:0] e;
        for (int k = 0; k < 5; k++) begin
            e = ref_fn(op_of(k), v.a, v.b);
            if (v.y[k] == e) begin
                m_pass[k] = sat(m_pass[k], k);
            end else begin
                m_fail[k] = sat(m_fail[k], k);
                if (!m_err[k]) begin
                    m_err[k]  = 1'b1;
                    m_fidx[k] = v.idx[k];
                    m_fa[k]   = v.a;
                    m_fb[k]   = v.b;
                    m_fy[k]   = v.y[k];
                end
            end
        end
    endtask

    // A vector is scored one edge after it is accepted; the edge that scores
    // the last vector ends the run and accepts nothing.
    task automatic model_edge();
        vec_t v;
        bit   finishing;
        finishing = 1'b0;
        if (m_state == 1) begin
            if (m_pipe.size() > 0) begin
                v = m_pipe.pop_front();
                score(v);
                finishing = v.last;
            end
            if (valid && !finishing) begin
                v.a    = a;
                v.b    = b;
                v.last = last;
                for (int k = 0; k < 5; k++) begin
                    if (k == 4) v.y[k] = y_drv[0];
                    else        v.y[k] = y_drv[k];
                    v.idx[k] = m_idx[k];
                    m_idx[k] = sat(m_idx[k], k);
                end
                m_pipe.push_back(v);
            end
            if (finishing) m_state = 2;
        end else if (start) begin
            model_reset();
            m_state = 1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic check_inst(input int k, input logic bz, input logic dn, input logic er,
                              input logic [15:0] p, input logic [15:0] f, input logic [15:0] ix,
                              input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] xy);
        chk($sformatf("u%0d.busy", k),     16'(bz), 16'(m_state == 1));
        chk($sformatf("u%0d.done", k),     16'(dn), 16'(m_state == 2));
        chk($sformatf("u%0d.error", k),    16'(er), 16'(m_err[k]));
        chk($sformatf("u%0d.pass_cnt", k), p,  m_pass[k]);
        chk($sformatf("u%0d.fail_cnt", k), f,  m_fail[k]);
        chk($sformatf("u%0d.fail_idx", k), ix, m_fidx[k]);
        chk($sformatf("u%0d.fail_a", k),   xa, m_fa[k]);
        chk($sformatf("u%0d.fail_b", k),   xb, m_fb[k]);
        chk($sformatf("u%0d.fail_y", k),   xy, m_fy[k]);
    endtask

    task automatic check_output();
        for (int k = 0; k < 4; k++) begin
            check_inst(k, busy_o[k], done_o[k], err_o[k], pass_o[k], fail_o[k],
                       fidx_o[k], fa_o[k], fb_o[k], fy_o[k]);
        end
        check_inst(4, busy4, done4, err4, {14'b0, pass4}, {14'b0, fail4},
                   {14'b0, fidx4}, fa4, fb4, fy4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] z, input logic ls,
                                  input logic [15:0] m0, input logic [15:0] m1,
                                  input logic [15:0] m2, input logic [15:0] m3);
        start    = 1'b0;
        valid    = 1'b1;
        a        = x;
        b        = z;
        last     = ls;
        y_drv[0] = ref_fn(0, x, z) ^ m0;
        y_drv[1] = ref_fn(1, x, z) ^ m1;
        y_drv[2] = ref_fn(2, x, z) ^ m2;
        y_drv[3] = ref_fn(3, x, z) ^ m3;
        tick();
    endtask

    task automatic apply_raw(input logic [15:0] x, input logic [15:0] z, input logic ls,
                             input logic [15:0] y0, input logic [15:0] y1,
                             input logic [15:0] y2, input logic [15:0] y3);
        start    = 1'b0;
        valid    = 1'b1;
        a        = x;
        b        = z;
        last     = ls;
        y_drv[0] = y0;
        y_drv[1] = y1;
        y_drv[2] = y2;
        y_drv[3] = y3;
        tick();
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        tick();
    endtask

    task automatic start_run(input bit with_valid);
        start = 1'b1;
        valid = with_valid;
        last  = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        for (int k = 0; k < 4; k++) y_drv[k] = 16'($urandom);
        tick();
        start = 1'b0;
        valid = 1'b0;
        chk("start.busy",     16'(busy_o[0]), 16'd1);
        chk("start.done",     16'(done_o[0]), 16'd0);
        chk("start.error",    16'(err_o[0]),  16'd0);
        chk("start.pass_cnt", pass_o[0], 16'd0);
        chk("start.fail_cnt", fail_o[0], 16'd0);
        chk("start.fail_idx", fidx_o[0], 16'd0);
        chk("start.fail_a",   fa_o[0],   16'd0);
        chk("start.fail_b",   fb_o[0],   16'd0);
        chk("start.fail_y",   fy_o[0],   16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int len;

        scen[0] = '{4'b0000, 16'd4, 16'd0, 1'b0, 16'd0, 16'h0000, 16'h0000, 16'h0000};
        scen[1] = '{4'b0100, 16'd3, 16'd1, 1'b1, 16'd2, 16'h0000, 16'hffff, 16'h0001};
        scen[2] = '{4'b1010, 16'd2, 16'd2, 1'b1, 16'd1, 16'hffff, 16'h0000, 16'h0001};

        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        a     = '0;
        b     = '0;
        for (int k = 0; k < 4; k++) y_drv[k] = '0;
        model_reset();
        #2;
        check_output();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // valid while idle must not count anything
        apply_stimulus(16'h1234, 16'h00ff, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        apply_stimulus(16'hffff, 16'hffff, 1'b0, 16'h1, 16'h0, 16'h0, 16'h0);
        chk("idle_valid.pass_cnt", pass_o[0], 16'd0);
        chk("idle_valid.fail_cnt", fail_o[0], 16'd0);
        chk("idle_valid.busy",     16'(busy_o[0]), 16'd0);

        for (int s = 0; s < 3; s++) begin
            start_run(1'b0);
            for (int i = 0; i < 4; i++) begin
                apply_stimulus(va[i], vb[i], (i == 3),
                               scen[s].fault[i] ? 16'h0001 : 16'h0000, 16'h0, 16'h0, 16'h0);
            end
            chk($sformatf("scen%0d.done_before", s), 16'(done_o[0]), 16'd0);
            idle_cycle();
            chk($sformatf("scen%0d.done_after", s), 16'(done_o[0]), 16'd1);
            chk($sformatf("scen%0d.busy_after", s), 16'(busy_o[0]), 16'd0);
            chk($sformatf("scen%0d.pass_cnt", s), pass_o[0], scen[s].e_pass);
            chk($sformatf("scen%0d.fail_cnt", s), fail_o[0], scen[s].e_fail);
            chk($sformatf("scen%0d.error", s),    16'(err_o[0]), 16'(scen[s].e_err));
            chk($sformatf("scen%0d.fail_idx", s), fidx_o[0], scen[s].e_idx);
            chk($sformatf("scen%0d.fail_a", s),   fa_o[0],   scen[s].e_fa);
            chk($sformatf("scen%0d.fail_b", s),   fb_o[0],   scen[s].e_fb);
            chk($sformatf("scen%0d.fail_y", s),   fy_o[0],   scen[s].e_fy);
        end

        // XOR and NAND references with hand-computed responses; start carries a
        // valid that must be ignored
        start_run(1'b1);
        apply_raw(16'h00ff, 16'h0ff0, 1'b0, 16'h00f0, 16'h0fff, 16'h0f0f, 16'hff0f);
        apply_raw(16'hffff, 16'hffff, 1'b1, 16'hffff, 16'hffff, 16'h0000, 16'h0000);
        idle_cycle();
        chk("xor.pass_cnt",  pass_o[2], 16'd2);
        chk("xor.fail_cnt",  fail_o[2], 16'd0);
        chk("nand.pass_cnt", pass_o[3], 16'd2);
        chk("nand.fail_cnt", fail_o[3], 16'd0);
        chk("nand.error",    16'(err_o[3]), 16'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom), 16'h0, 16'h0, 16'h0, 16'h0);
        end
        chk("done_valid.pass_cnt", pass_o[2], 16'd2);
        chk("done_valid.done",     16'(done_o[2]), 16'd1);

        // asynchronous reset with one vector still in the sample stage
        start_run(1'b0);
        apply_stimulus(16'hffff, 16'hffff, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        apply_stimulus(16'hffff, 16'h0000, 1'b0, 16'h8000, 16'h0, 16'h0, 16'h0);
        idle_cycle();
        chk("prereset.pass_cnt", pass_o[0], 16'd1);
        chk("prereset.fail_cnt", fail_o[0], 16'd1);
        chk("prereset.fail_idx", fidx_o[0], 16'd1);
        apply_stimulus(16'h0000, 16'hffff, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        chk("reset.pass_cnt", pass_o[0], 16'd0);
        chk("reset.error",    16'(err_o[0]), 16'd0);
        chk("reset.fail_a",   fa_o[0], 16'd0);
        chk("reset.busy",     16'(busy_o[0]), 16'd0);
        valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        apply_stimulus(16'h0f0f, 16'h00ff, 1'b0, 16'h1, 16'h0, 16'h0, 16'h0);
        apply_stimulus(16'h0f0f, 16'h00ff, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("post_reset.busy",     16'(busy_o[0]), 16'd0);
        chk("post_reset.fail_cnt", fail_o[0], 16'd0);
        start_run(1'b0);
        apply_stimulus(16'h1111, 16'h2222, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        idle_cycle();

        // narrow counters saturate
        start_run(1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(16'($urandom), 16'($urandom), (i == 4), 16'h0, 16'h0, 16'h0, 16'h0);
        end
        idle_cycle();
        chk("sat.pass_cnt",  {14'b0, pass4}, 16'd3);
        chk("sat.fail_cnt",  {14'b0, fail4}, 16'd0);
        chk("sat.done",      16'(done4), 16'd1);
        chk("sat.wide_pass", pass_o[0], 16'd5);

        // randomized runs with gaps, faults and traffic after last
        for (int r = 0; r < 40; r++) begin
            start_run(1'($urandom_range(0, 1)));
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                apply_stimulus(16'($urandom), 16'($urandom), (i == len - 1),
                               rmask(), rmask(), rmask(), rmask());
            end
            for (int i = 0; i < 2; i++) begin
                apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom),
                               rmask(), rmask(), rmask(), rmask());
            end
            chk("rand.done", 16'(done_o[0]), 16'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
